// File: rtl/pid_sequencer_if.sv
// Sample/operand bundle between the inertial front end and the PID sequencer.
// The master drives samples and mode bits; the slave (sequencer) returns the PID operands.
interface pid_sequencer_if;
  logic               vld;
  logic signed [15:0] ptch;
  logic               pwr_up;
  logic               rider_off;
  logic signed [9:0]  ptch_err_sat;
  logic signed [9:0]  ptch_err_I;
  logic signed [6:0]  ptch_D_diff_sat;
  logic               pid_vld;
  logic               busy;
  logic               smpl_drop;

  modport master (
    output vld, ptch, pwr_up, rider_off,
    input  ptch_err_sat, ptch_err_I, ptch_D_diff_sat, pid_vld, busy, smpl_drop
  );

  modport slave (
    input  vld, ptch, pwr_up, rider_off,
    output ptch_err_sat, ptch_err_I, ptch_D_diff_sat, pid_vld, busy, smpl_drop
  );
endinterface

// File: rtl/pid_sequencer.sv
// PID operand sequencer: saturate -> integrate -> differentiate -> publish, one update per sample.
// Optional macro INTEG_DECIM_EN: integrator accumulates only on every second accepted sample.
module pid_sequencer #(
  parameter int D_DEPTH = 2,
  parameter int INT_W   = 18
) (
  input  logic           clk,
  input  logic           rst,
  pid_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SAT   = 3'd1;
  localparam logic [2:0] INTEG = 3'd2;
  localparam logic [2:0] DIFF  = 3'd3;
  localparam logic [2:0] PUB   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic signed [9:0]       err_q;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [9:0]       hist_q [D_DEPTH];
  logic signed [9:0]       err_out_q;
  logic signed [9:0]       i_out_q;
  logic signed [6:0]       diff_out_q;
  logic                    smpl_drop_q;
  logic                    accept;
  logic                    add_en;

  logic signed [INT_W-1:0] err_ext;
  logic signed [INT_W-1:0] sum;
  logic                    ovf;
  logic signed [10:0]      diff_w;
  logic signed [6:0]       diff_d;

  function automatic logic signed [9:0] sat10(input logic signed [15:0] x);
    if (x > 16'sd511)       return 10'sh1FF;
    else if (x < -16'sd512) return 10'sh200;
    else                    return x[9:0];
  endfunction

  function automatic logic signed [6:0] sat7(input logic signed [10:0] x);
    if (x > 11'sd63)       return 7'sh3F;
    else if (x < -11'sd64) return 7'sh40;
    else                   return x[6:0];
  endfunction

  // IDLE is the only accept point; the sample is saturated straight off the bus.
  assign accept = (state_q == IDLE) && bus.vld;

`ifdef INTEG_DECIM_EN
  logic tgl_q;

  always_ff @(posedge clk) begin
    if (rst)         tgl_q <= 1'b0;
    else if (accept) tgl_q <= ~tgl_q;
  end

  assign add_en = tgl_q;
`else
  assign add_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.vld) state_d = SAT;
      SAT:     state_d = INTEG;
      INTEG:   state_d = DIFF;
      DIFF:    state_d = PUB;
      PUB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Signed overflow: operands agree in sign but the sum does not; the integrator then holds.
  assign err_ext = {{(INT_W-10){err_q[9]}}, err_q};
  assign sum     = integ_q + err_ext;
  assign ovf     = (integ_q[INT_W-1] == err_ext[INT_W-1]) && (sum[INT_W-1] != integ_q[INT_W-1]);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    integ_d = integ_q;
    if (state_q == INTEG) begin
      if (bus.rider_off || !bus.pwr_up) integ_d = '0;
      else if (add_en && !ovf)          integ_d = sum;
    end
  end

  assign diff_w = {err_q[9], err_q} - {hist_q[D_DEPTH-1][9], hist_q[D_DEPTH-1]};
  assign diff_d = bus.pwr_up ? sat7(diff_w) : 7'sd0;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      err_q       <= '0;
      integ_q     <= '0;
      err_out_q   <= '0;
      i_out_q     <= '0;
      diff_out_q  <= '0;
      smpl_drop_q <= 1'b0;
      // NOTE: the history is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      integ_q <= integ_d;
      if (accept) err_q <= sat10(bus.ptch);
      if (bus.vld && (state_q != IDLE)) smpl_drop_q <= 1'b1;

      // Outputs load on the DIFF->PUB edge so they are valid alongside pid_vld in PUB.
      if (state_q == DIFF) begin
        if (!bus.pwr_up) begin
          for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
        end else begin
          for (int i = D_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
          hist_q[0] <= err_q;
        end
        err_out_q  <= err_q;
        i_out_q    <= integ_q[INT_W-1 -: 10];
        diff_out_q <= diff_d;
      end
    end
  end

  assign bus.ptch_err_sat    = err_out_q;
  assign bus.ptch_err_I      = i_out_q;
  assign bus.ptch_D_diff_sat = diff_out_q;
  assign bus.pid_vld         = (state_q == PUB);
  assign bus.busy            = (state_q != IDLE);
  assign bus.smpl_drop       = smpl_drop_q;

endmodule
